// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin quantum arbiter.
package wrr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index of the highest set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic int unsigned oh2idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of vec scanning upward
// from start with wrap-around.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int p;
    found = |vec;
    idx   = '0;
    p     = 0;
    // Scan from the far end back so the candidate closest to start wins last.
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(start) + k) % N;
      if (vec[p]) idx = IDX_W'(p);
    end
  end

endmodule

// File: rtl/wrr_quantum_arbiter.sv
// Weighted round-robin arbiter: a holder keeps the grant for up to its
// programmable quantum while others wait; a lone requester holds indefinitely.
module wrr_quantum_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N              = 4,
  parameter int WEIGHT_W       = 4,
  parameter int DEFAULT_WEIGHT = 2,
  localparam int IDX_W         = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        grant,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_id,
  output logic                switch_pulse,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [WEIGHT_W-1:0] cfg_weight
);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] cnt;
  logic [WEIGHT_W-1:0] weight [N];

  logic [IDX_W-1:0] hnext;
  logic [IDX_W-1:0] start_a;
  logic [N-1:0]     mask_b;
  logic             a_found, b_found;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic [N-1:0]     oh_a, oh_b;

  // Remaining extra cycles to load for a new tenure; a zero weight acts as one.
  function automatic logic [WEIGHT_W-1:0] quantum_load(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  assign hnext   = (grant_id == IDX_W'(N - 1)) ? '0 : grant_id + 1'b1;
  assign start_a = (state == IDLE) ? ptr : hnext;
  assign mask_b  = req & ~grant;
  assign oh_a    = N'(1) << a_idx;
  assign oh_b    = N'(1) << b_idx;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_any (
    .vec   (req),
    .start (start_a),
    .found (a_found),
    .idx   (a_idx)
  );

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick_other (
    .vec   (mask_b),
    .start (hnext),
    .found (b_found),
    .idx   (b_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      switch_pulse <= 1'b0;
      for (int i = 0; i < N; i++) weight[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
    end else begin
      switch_pulse <= 1'b0;
      // Quantum loads below read weight before this write lands.
      if (cfg_we && (int'(cfg_idx) < N)) weight[cfg_idx] <= cfg_weight;

      case (state)
        IDLE: begin
          if (a_found) begin
            state        <= BUSY;
            grant        <= oh_a;
            grant_valid  <= 1'b1;
            grant_id     <= IDX_W'(oh2idx(32'(oh_a)));
            cnt          <= quantum_load(weight[a_idx]);
            switch_pulse <= 1'b1;
          end
        end
        BUSY: begin
          if (!req[grant_id]) begin
            ptr <= hnext;
            if (a_found) begin
              grant        <= oh_a;
              grant_id     <= IDX_W'(oh2idx(32'(oh_a)));
              cnt          <= quantum_load(weight[a_idx]);
              switch_pulse <= 1'b1;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
              cnt         <= '0;
            end
          end else if (cnt == '0) begin
            if (b_found) begin
              ptr          <= hnext;
              grant        <= oh_b;
              grant_id     <= IDX_W'(oh2idx(32'(oh_b)));
              cnt          <= quantum_load(weight[b_idx]);
              switch_pulse <= 1'b1;
            end else begin
              cnt <= quantum_load(weight[grant_id]);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_quantum_arbiter.sv
// Self-checking bench for wrr_quantum_arbiter: directed scenarios and random
// traffic compared against a tenure-level reference model.
module tb_wrr_quantum_arbiter;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int IDX_W = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IDX_W-1:0] grant_id;
  logic          switch_pulse;
  logic          cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [WW-1:0] cfg_weight;

  int tests  = 0;
  int failed = 0;

  // Reference model: holder (-1 idle), cycles used in tenure, tenure length,
  // round-robin pointer and weight table.
  int m_holder, m_used, m_quota, m_ptr;
  int m_w [N];
  bit m_pulse;

  always #5 clk = ~clk;

  wrr_quantum_arbiter #(.N(N), .WEIGHT_W(WW), .DEFAULT_WEIGHT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .switch_pulse (switch_pulse),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_weight   (cfg_weight)
  );

  function automatic int pick(input logic [N-1:0] v, input int s);
    for (int k = 0; k < N; k++) begin
      if (v[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  function automatic int weff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic start_tenure(input int h);
    m_holder = h;
    m_used   = 1;
    m_quota  = weff(m_w[h]);
    m_pulse  = 1'b1;
  endtask

  task automatic model_edge();
    int n;
    logic [N-1:0] others;
    if (!rst_n) begin
      m_holder = -1; m_used = 0; m_quota = 0; m_ptr = 0; m_pulse = 1'b0;
      for (int i = 0; i < N; i++) m_w[i] = 2;
      return;
    end
    m_pulse = 1'b0;
    if (m_holder < 0) begin
      n = pick(req, m_ptr);
      if (n >= 0) start_tenure(n);
    end else if (!req[m_holder]) begin
      m_ptr = (m_holder + 1) % N;
      n = pick(req, m_ptr);
      if (n >= 0) start_tenure(n);
      else m_holder = -1;
    end else if (m_used >= m_quota) begin
      others = req & ~(N'(1) << m_holder);
      if (others != '0) begin
        n = pick(others, (m_holder + 1) % N);
        m_ptr = (m_holder + 1) % N;
        start_tenure(n);
      end else begin
        m_used  = 1;
        m_quota = weff(m_w[m_holder]);
      end
    end else begin
      m_used++;
    end
    if (cfg_we && int'(cfg_idx) < N) m_w[cfg_idx] = int'(cfg_weight);
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic we = 1'b0, input int idx = 0,
                      input int w = 0, input logic rn = 1'b1);
    logic [N-1:0] eg;
    req = r; cfg_we = we; cfg_idx = IDX_W'(idx); cfg_weight = WW'(w); rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_holder < 0) ? '0 : N'(1) << m_holder;
    check("grant", 32'(grant), 32'(eg));
    check("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
    check("grant_id", 32'(grant_id), (m_holder < 0) ? 0 : m_holder);
    check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
  endtask

  initial begin
    logic [N-1:0] rot_seq [9];
    logic [N-1:0] r;
    rot_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001};
    m_holder = -1; m_used = 0; m_quota = 0; m_ptr = 0; m_pulse = 1'b0;
    for (int i = 0; i < N; i++) m_w[i] = 2;
    rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;

    // Reset and idle
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 0, 0, 1'b0);
    check("reset_grant", 32'(grant), 0);
    for (int i = 0; i < 2; i++) step(4'b0000);

    // Default weights, everyone requesting
    for (int i = 0; i < 9; i++) begin
      step(4'b1111);
      check("rot_seq", 32'(grant), 32'(rot_seq[i]));
    end

    // Programmed weights 3,1,0,1 with requester 3 idle
    step(4'b0000, 1'b0, 0, 0, 1'b0);
    step(4'b0000, 1'b1, 0, 3);
    step(4'b0000, 1'b1, 1, 1);
    step(4'b0000, 1'b1, 2, 0);
    step(4'b0000, 1'b1, 3, 1);
    for (int i = 0; i < 12; i++) begin
      step(4'b0111);
      check("no_grant3", 32'(grant[3]), 0);
    end

    // Early release: no dead cycle, ptr moves past the releaser
    step(4'b0000, 1'b0, 0, 0, 1'b0);
    step(4'b0011);
    step(4'b0010);
    check("early_release", 32'(grant), 32'(4'b0010));
    for (int i = 0; i < 4; i++) step(4'b0011);

    // Lone requester holds indefinitely
    step(4'b0000, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0100);
    step(4'b0000);
    check("lone_drop", 32'(grant), 0);

    // Mid-tenure weight write, then reset mid-tenure
    step(4'b0000, 1'b0, 0, 0, 1'b0);
    step(4'b0000, 1'b1, 1, 3);
    step(4'b0011);
    step(4'b0011);
    step(4'b0011);
    step(4'b0011, 1'b1, 1, 1);
    step(4'b0011);
    check("tenure_kept", 32'(grant), 32'(4'b0010));
    for (int i = 0; i < 4; i++) step(4'b0011);
    step(4'b0011, 1'b0, 0, 0, 1'b0);
    check("mid_reset", 32'(grant), 0);
    for (int i = 0; i < 6; i++) step(4'b1111);

    // Random traffic with occasional config writes and resets
    r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step(r, ($urandom_range(0, 9) == 0), int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, 5)), ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
